// File: rtl/nand_exhaustive_checker.sv
// Exhaustive self-test driver/checker for a two-input NAND cell.
// Drives the four A/B vectors in order, waits a programmable settle time,
// samples the gate output once per vector and tallies mismatches.
module nand_exhaustive_checker #(
  parameter int SETTLE_CYCLES = 2,  // 1..255
  parameter int ROUNDS        = 4,  // 1..255
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Counter reload value and final-round index, narrowed to the counter width.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_ROUND  = 8'(ROUNDS - 1);

  state_t           r_state;
  logic [7:0]       r_settle;
  logic [7:0]       r_round;
  logic [1:0]       r_vec;
  logic             r_a;
  logic             r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic             r_ffv;
  logic [1:0]       r_ffvec;

  logic             w_expected;
  logic             w_mismatch;
  logic             w_err_sat;
  logic [ERR_W-1:0] w_err_next;
  logic             w_last_vec;
  logic [1:0]       w_vec_next;

  // Sample-cycle helpers: golden NAND value, saturating error update, end-of-run test.
  assign w_expected = ~(r_a & r_b);
  assign w_mismatch = (y_in != w_expected);
  assign w_err_sat  = &r_err;
  assign w_err_next = (w_mismatch && !w_err_sat) ? r_err + 1'b1 : r_err;
  assign w_last_vec = (r_vec == 2'd3) && (r_round == LAST_ROUND);
  assign w_vec_next = r_vec + 2'd1;

  // Control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_settle <= '0;
      r_round  <= '0;
      r_vec    <= '0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_ffv    <= 1'b0;
      r_ffvec  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // A run may only be launched from rest; results persist until then.
          if (start) begin
            r_state  <= ST_SETTLE;
            r_settle <= SETTLE_LOAD;
            r_round  <= '0;
            r_vec    <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_ffv    <= 1'b0;
            r_ffvec  <= '0;
          end
        end
        ST_SETTLE: begin
          // Hold the vector for SETTLE_CYCLES cycles (counter runs LOAD..0).
          if (r_settle == 8'd0) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle - 8'd1;
          end
        end
        ST_SAMPLE: begin
          // y_in is only looked at here, after the gate has had time to settle.
          r_err <= w_err_next;
          if (w_mismatch && !r_ffv) begin
            r_ffv   <= 1'b1;
            r_ffvec <= r_vec;
          end
          if (w_last_vec) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_state  <= ST_SETTLE;
            r_settle <= SETTLE_LOAD;
            r_vec    <= w_vec_next;
            r_a      <= w_vec_next[1];
            r_b      <= w_vec_next[0];
            if (r_vec == 2'd3) begin
              r_round <= r_round + 8'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_out            = r_a;
  assign b_out            = r_b;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign vec_idx          = r_vec;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_nand_exhaustive_checker.sv
// Randomized self-checking bench for nand_exhaustive_checker.
// Two instances share clk/rst/start/y_in: ERR_W=8 and ERR_W=2 (saturation).
module tb_nand_exhaustive_checker;

  localparam int S    = 2;
  localparam int R    = 4;
  localparam int NV   = R * 4;
  localparam int RUN  = NV * (S + 1);
  localparam int TAIL = 6;
  localparam int NC   = RUN + TAIL;

  localparam int M_IDEAL  = 0;  // gate correct at all times
  localparam int M_NOISE  = 1;  // random garbage while settling
  localparam int M_STUCK0 = 2;
  localparam int M_STUCK1 = 3;
  localparam int M_INVSET = 4;  // wrong during settle, right at sample

  logic clk = 1'b0;
  logic rst, start, y_in;

  logic       a1, b1, busy1, done1, pass1, ffv1;
  logic [7:0] err1;
  logic [1:0] vec1, ffvec1;
  logic       a2, b2, busy2, done2, pass2, ffv2;
  logic [1:0] err2;
  logic [1:0] vec2, ffvec2;

  int errors = 0;
  int checks = 0;

  logic       obs_a    [NC];
  logic       obs_b    [NC];
  logic       obs_busy [NC];
  logic       obs_done [NC];
  logic [1:0] obs_vec  [NC];
  logic [7:0] obs_err  [NC];
  logic       ysamp    [NV];

  always #5 clk = ~clk;

  nand_exhaustive_checker #(.SETTLE_CYCLES(S), .ROUNDS(R), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .vec_idx(vec1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  nand_exhaustive_checker #(.SETTLE_CYCLES(S), .ROUNDS(R), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .vec_idx(vec2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  function automatic logic nand_of(input int v);
    return ~(v[1] & v[0]);
  endfunction

  // Reference: number of sampled values differing from the NAND truth table.
  function automatic int model_errs();
    int n = 0;
    for (int k = 0; k < NV; k++)
      if (ysamp[k] != nand_of(k % 4)) n++;
    return n;
  endfunction

  // Reference: vector index of the first wrong sample, or -1 when none.
  function automatic int model_ffvec();
    for (int k = 0; k < NV; k++)
      if (ysamp[k] != nand_of(k % 4)) return k % 4;
    return -1;
  endfunction

  // Pulse start, then act as the gate under test cycle by cycle, recording outputs.
  // Cycle c is the c-th cycle after the start edge; vector k is sampled at c=k*(S+1)+S.
  task automatic drive_run(input int mode, input logic [15:0] flips,
                           input int start_at, input int rst_at, output int dcyc);
    int   k, pos;
    logic y;
    dcyc = -1;
    @(negedge clk);
    start = 1'b1;
    y_in  = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < NC; c++) begin
      if (c > 0) @(negedge clk);
      obs_a[c]    = a1;
      obs_b[c]    = b1;
      obs_busy[c] = busy1;
      obs_done[c] = done1;
      obs_vec[c]  = vec1;
      obs_err[c]  = err1;
      if (done1 && dcyc < 0) dcyc = c;
      start = (c == start_at);
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      k   = c / (S + 1);
      pos = c % (S + 1);
      if (c >= RUN)               y = 1'($urandom_range(0, 1));
      else if (mode == M_STUCK0)  y = 1'b0;
      else if (mode == M_STUCK1)  y = 1'b1;
      else if (pos == S)          y = nand_of(k % 4) ^ flips[k];
      else if (mode == M_NOISE)   y = 1'($urandom_range(0, 1));
      else if (mode == M_INVSET)  y = ~nand_of(k % 4);
      else                        y = nand_of(k % 4);
      if (c < RUN && pos == S) ysamp[k] = y;
      y_in = y;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; y_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a1, b1, busy1, done1, pass1, ffv1} !== 6'b0) begin
      errors++; $display("FAIL reset_flags1: got %b expected 000000", {a1, b1, busy1, done1, pass1, ffv1});
    end
    checks++;
    if ({err1, vec1, ffvec1} !== 12'b0) begin
      errors++; $display("FAIL reset_counts1: got %h expected 000", {err1, vec1, ffvec1});
    end
    checks++;
    if ({a2, b2, busy2, done2, pass2, ffv2, err2, vec2, ffvec2} !== 12'b0) begin
      errors++; $display("FAIL reset_sat: got %h expected 000", {a2, b2, busy2, done2, pass2, ffv2, err2, vec2, ffvec2});
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      y_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({busy1, done1, err1} !== 10'b0) begin
        errors++; $display("FAIL idle_hold: got busy=%b done=%b err=%0d expected 0 0 0", busy1, done1, err1);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_ideal();
    int dc;
    logic [1:0] ev;
    logic eb;
    drive_run(M_IDEAL, 16'h0, -1, -1, dc);
    checks++;
    if (dc !== RUN) begin errors++; $display("FAIL ideal_latency: got %0d expected %0d", dc, RUN); end
    for (int c = 0; c < NC; c++) begin
      ev = (c < RUN) ? 2'((c / (S + 1)) % 4) : 2'd3;
      eb = (c < RUN);
      checks++;
      if ({obs_a[c], obs_b[c], obs_vec[c], obs_busy[c], obs_done[c]} !== {ev[1], ev[0], ev, eb, ~eb}) begin
        errors++;
        $display("FAIL ideal_trace c=%0d: got a=%b b=%b vec=%0d busy=%b done=%b expected vec=%0d busy=%b",
                 c, obs_a[c], obs_b[c], obs_vec[c], obs_busy[c], obs_done[c], ev, eb);
      end
    end
    checks++;
    if ({pass1, err1, ffv1} !== {1'b1, 8'd0, 1'b0}) begin
      errors++; $display("FAIL ideal_result: got pass=%b err=%0d ffv=%b expected 1 0 0", pass1, err1, ffv1);
    end
    $display("test_ideal: done_cycle=%0d pass=%b err=%0d", dc, pass1, err1);
  endtask

  task automatic test_stuck1();
    int dc;
    drive_run(M_STUCK1, 16'h0, -1, -1, dc);
    checks++;
    if ({pass1, err1, ffv1, ffvec1} !== {1'b0, 8'd4, 1'b1, 2'd3}) begin
      errors++; $display("FAIL stuck1: got pass=%b err=%0d ffv=%b ffvec=%0d expected 0 4 1 3", pass1, err1, ffv1, ffvec1);
    end
    checks++;
    if ({pass2, err2} !== {1'b0, 2'd3}) begin
      errors++; $display("FAIL stuck1_sat: got pass=%b err=%0d expected 0 3", pass2, err2);
    end
    checks++;
    if (dc !== RUN) begin errors++; $display("FAIL stuck1_latency: got %0d expected %0d", dc, RUN); end
    $display("test_stuck1: err=%0d ffvec=%0d", err1, ffvec1);
  endtask

  task automatic test_stuck0();
    int dc;
    drive_run(M_STUCK0, 16'h0, -1, -1, dc);
    checks++;
    if ({pass2, err2, ffv2, ffvec2} !== {1'b0, 2'd3, 1'b1, 2'd0}) begin
      errors++; $display("FAIL stuck0_sat: got pass=%b err=%0d ffv=%b ffvec=%0d expected 0 3 1 0", pass2, err2, ffv2, ffvec2);
    end
    checks++;
    if (err1 !== 8'd12) begin errors++; $display("FAIL stuck0_raw: got %0d expected 12", err1); end
    $display("test_stuck0: err8=%0d err2=%0d", err1, err2);
  endtask

  task automatic test_sampling_point();
    int dc;
    drive_run(M_INVSET, 16'h0, -1, -1, dc);
    checks++;
    if ({pass1, err1, ffv1} !== {1'b1, 8'd0, 1'b0}) begin
      errors++; $display("FAIL sample_point: got pass=%b err=%0d ffv=%b expected 1 0 0", pass1, err1, ffv1);
    end
    $display("test_sampling_point: pass=%b err=%0d", pass1, err1);
  endtask

  task automatic test_random();
    int dc, me, mf, m2;
    logic [15:0] fl;
    for (int r = 0; r < 8; r++) begin
      fl = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'($urandom) & 16'($urandom) & 16'($urandom));
      drive_run(M_NOISE, fl, -1, -1, dc);
      me = model_errs();
      mf = model_ffvec();
      m2 = (me > 3) ? 3 : me;
      checks++;
      if (err1 !== 8'(me)) begin errors++; $display("FAIL rand_err run=%0d: got %0d expected %0d", r, err1, me); end
      checks++;
      if (err2 !== 2'(m2)) begin errors++; $display("FAIL rand_err_sat run=%0d: got %0d expected %0d", r, err2, m2); end
      checks++;
      if (pass1 !== (me == 0) || pass2 !== (me == 0)) begin
        errors++; $display("FAIL rand_pass run=%0d: got %b/%b expected %b", r, pass1, pass2, (me == 0));
      end
      checks++;
      if (ffv1 !== (mf >= 0) || (mf >= 0 && ffvec1 !== 2'(mf))) begin
        errors++; $display("FAIL rand_ffvec run=%0d: got ffv=%b vec=%0d expected %0d", r, ffv1, ffvec1, mf);
      end
      checks++;
      if (dc !== RUN) begin errors++; $display("FAIL rand_latency run=%0d: got %0d expected %0d", r, dc, RUN); end
      $display("test_random run=%0d flips=%h err=%0d model=%0d ffvec_model=%0d", r, fl, err1, me, mf);
    end
  endtask

  task automatic test_rst_midrun();
    int dc;
    // Round 1, vector 2, first settle cycle.
    drive_run(M_IDEAL, 16'h0, -1, 6 * (S + 1), dc);
    checks++;
    if ({a1, b1, busy1, done1, pass1, ffv1, err1, vec1, ffvec1} !== 18'b0) begin
      errors++; $display("FAIL rst_mid: got %h expected 00000", {a1, b1, busy1, done1, pass1, ffv1, err1, vec1, ffvec1});
    end
    drive_run(M_IDEAL, 16'h0, -1, -1, dc);
    checks++;
    if (dc !== RUN || pass1 !== 1'b1) begin
      errors++; $display("FAIL rst_rerun: got done_cycle=%0d pass=%b expected %0d 1", dc, pass1, RUN);
    end
    $display("test_rst_midrun: rerun done_cycle=%0d pass=%b", dc, pass1);
  endtask

  task automatic test_back_to_back();
    int dc;
    logic [1:0] ev;
    drive_run(M_STUCK1, 16'h0, 10, -1, dc);
    checks++;
    if (dc !== RUN || err1 !== 8'd4) begin
      errors++; $display("FAIL busy_start: got done_cycle=%0d err=%0d expected %0d 4", dc, err1, RUN);
    end
    for (int c = 0; c < RUN; c++) begin
      ev = 2'((c / (S + 1)) % 4);
      checks++;
      if (obs_vec[c] !== ev || obs_busy[c] !== 1'b1) begin
        errors++; $display("FAIL busy_start_trace c=%0d: got vec=%0d busy=%b expected %0d 1", c, obs_vec[c], obs_busy[c], ev);
      end
    end
    // Results from the stuck-at-1 run must hold in DONE regardless of y_in.
    checks++;
    if ({done1, err1, ffvec1} !== {1'b1, 8'd4, 2'd3}) begin
      errors++; $display("FAIL done_hold: got done=%b err=%0d ffvec=%0d expected 1 4 3", done1, err1, ffvec1);
    end
    // Restart from DONE: first cycle shows cleared counters.
    drive_run(M_IDEAL, 16'h0, -1, -1, dc);
    checks++;
    if (obs_err[0] !== 8'd0 || obs_done[0] !== 1'b0 || obs_busy[0] !== 1'b1) begin
      errors++; $display("FAIL restart: got err=%0d done=%b busy=%b expected 0 0 1", obs_err[0], obs_done[0], obs_busy[0]);
    end
    checks++;
    if (dc !== RUN || pass1 !== 1'b1) begin
      errors++; $display("FAIL restart_run: got done_cycle=%0d pass=%b expected %0d 1", dc, pass1, RUN);
    end
    $display("test_back_to_back: restart err0=%0d pass=%b", obs_err[0], pass1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; y_in = 1'b0;
    test_reset();
    test_ideal();
    test_stuck1();
    test_stuck0();
    test_sampling_point();
    test_random();
    test_rst_midrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
